register_bank: RTL and testbench

- Architectural storage for the 32 RISC-V integer registers x0..x31 in the single-cycle processor.
- Sits directly upstream of the two register-file read multiplexers (rs1, rs2). It drives every register value on a flattened bus; each read mux slices that bus into its 32 data inputs.
- Also owns the write side: a one-hot write decode from the write-back address, plus per-register enabled storage.

---
 rtl/register_bank_pkg.sv | 18 +
 rtl/enabled_register.sv | 29 ++
 rtl/register_bank.sv | 60 ++++++
 tb/tb_register_bank.sv | 133 +++++++++++++
 4 files changed

// File: rtl/register_bank_pkg.sv
// Shared constants for the integer register file: geometry, named
// architectural register indices and the default pointer reset values.
package register_bank_pkg;

  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;

  // Named architectural register indices
  localparam logic [REG_ADDR_W-1:0] ZERO = 5'd0;
  localparam logic [REG_ADDR_W-1:0] RA   = 5'd1;
  localparam logic [REG_ADDR_W-1:0] SP   = 5'd2;
  localparam logic [REG_ADDR_W-1:0] GP   = 5'd3;

  // Default reset values of the stack and global pointers
  localparam logic [31:0] SP_INIT_DEFAULT = 32'h7FFF_EFFC;
  localparam logic [31:0] GP_INIT_DEFAULT = 32'h1000_8000;

endpackage : register_bank_pkg

// File: rtl/enabled_register.sv
// Single N-bit storage register with synchronous reset to a
// per-instance value and a load enable; holds its value otherwise.
module enabled_register #(
  parameter int           N           = 32,
  parameter logic [N-1:0] RESET_VALUE = {N{1'b0}}
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] q_r;

  // Storage: reset wins over a load on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r <= RESET_VALUE;
    end else if (enable) begin
      q_r <= d;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule : enabled_register

// File: rtl/register_bank.sv
// Architectural storage for RISC-V x0..x31. Decodes the write-back
// address into a one-hot strobe and exposes every register on a
// flattened bus for the two read multiplexers. x0 is constant zero.
module register_bank
  import register_bank_pkg::*;
#(
  parameter int           N       = 32,
  parameter logic [N-1:0] SP_INIT = SP_INIT_DEFAULT,
  parameter logic [N-1:0] GP_INIT = GP_INIT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reg_write,
  input  logic [REG_ADDR_W-1:0] write_register,
  input  logic [N-1:0]          write_data,
  output logic [NUM_REGS*N-1:0] reg_bus,
  output logic [NUM_REGS-1:0]   write_onehot
);

  logic [NUM_REGS-1:0] write_onehot_s;

  // Write decode: reg_write gates every strobe so an unknown address
  // while idle cannot enable any register; index 0 never strobes
  always_comb begin
    write_onehot_s = {NUM_REGS{1'b0}};
    for (int k = 1; k < NUM_REGS; k++) begin
      if (reg_write && (write_register == REG_ADDR_W'(k))) begin
        write_onehot_s[k] = 1'b1;
      end else begin
        write_onehot_s[k] = 1'b0;
      end
    end
  end

  assign write_onehot = write_onehot_s;

  // x0 is hardwired to zero and has no storage
  assign reg_bus[N-1:0] = {N{1'b0}};

  genvar g;
  generate
    for (g = 1; g < NUM_REGS; g++) begin : g_reg
      localparam logic [N-1:0] INIT_VALUE =
        (g == int'(SP)) ? SP_INIT :
        (g == int'(GP)) ? GP_INIT : {N{1'b0}};

      enabled_register #(
        .N           (N),
        .RESET_VALUE (INIT_VALUE)
      ) u_reg (
        .clk    (clk),
        .reset  (reset),
        .enable (write_onehot_s[g]),
        .d      (write_data),
        .q      (reg_bus[g*N +: N])
      );
    end
  endgenerate

endmodule : register_bank

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank: directed scenarios followed by
// randomized traffic, all checked against an array-based reference model.
module tb_register_bank;

  localparam int N = 32;
  localparam logic [31:0] SP_RST = 32'h7FFF_EFFC;
  localparam logic [31:0] GP_RST = 32'h1000_8000;

  logic          clk;
  logic          reset;
  logic          reg_write;
  logic [4:0]    write_register;
  logic [N-1:0]  write_data;
  logic [32*N-1:0] reg_bus;
  logic [31:0]   write_onehot;

  logic [31:0] model [32];
  int total;
  int bad;

  register_bank dut (
    .clk            (clk),
    .reset          (reset),
    .reg_write      (reg_write),
    .write_register (write_register),
    .write_data     (write_data),
    .reg_bus        (reg_bus),
    .write_onehot   (write_onehot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Read-mux view: select one register out of the flattened bus
  function automatic logic [31:0] mux_sel(input logic [32*N-1:0] bus, input int sel);
    return bus[sel*N +: N];
  endfunction

  function automatic logic [31:0] exp_onehot(input logic we, input logic [4:0] wr);
    if (we && wr != 5'd0) return 32'd1 << wr;
    return 32'd0;
  endfunction

  task automatic check_all(input string tag);
    for (int k = 0; k < 32; k++)
      check_value($sformatf("%s_x%0d", tag, k), mux_sel(reg_bus, k), model[k]);
  endtask

  // Apply one cycle: drive inputs, check the strobe and that nothing
  // has changed yet, clock once, update the model, check every register
  task automatic cycle(input string tag, input logic rst, input logic we,
                       input logic [4:0] wr, input logic [31:0] wd);
    reset = rst; reg_write = we; write_register = wr; write_data = wd;
    #1;
    check_value({tag, "_onehot"}, write_onehot, exp_onehot(we, wr));
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 32; k++) model[k] = 32'd0;
      model[2] = SP_RST;
      model[3] = GP_RST;
    end else if (we && wr != 5'd0) begin
      model[wr] = wd;
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1; reg_write = 1'b0; write_register = 5'd0; write_data = 32'd0;
    for (int k = 0; k < 32; k++) model[k] = 32'd0;
    @(posedge clk); #1;

    // 1. reset held for two cycles
    cycle("rst1", 1'b1, 1'b0, 5'd0, 32'd0);
    cycle("rst2", 1'b1, 1'b0, 5'd0, 32'd0);

    // 2. basic write; old value visible during the write cycle
    reset = 1'b0; reg_write = 1'b1; write_register = 5'd5; write_data = 32'hDEAD_BEEF;
    #1;
    check_value("x5_before_write", mux_sel(reg_bus, 5), 32'd0);
    check_value("onehot_x5_const", write_onehot, 32'h0000_0020);
    cycle("wr5", 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    check_value("x5_const", mux_sel(reg_bus, 5), 32'hDEAD_BEEF);

    // 3. x0 protection
    cycle("wr0", 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    check_value("x0_const", mux_sel(reg_bus, 0), 32'd0);

    // 4. enable gating, then a full sweep
    cycle("gate7", 1'b0, 1'b0, 5'd7, 32'h1234_5678);
    check_value("x7_gated", mux_sel(reg_bus, 7), 32'd0);
    for (int k = 1; k < 32; k++) cycle("sweep", 1'b0, 1'b1, 5'(k), 32'(k + 100));
    for (int k = 1; k < 32; k++)
      check_value($sformatf("sweep_const_x%0d", k), mux_sel(reg_bus, k), 32'(k + 100));
    check_value("sweep_x0", mux_sel(reg_bus, 0), 32'd0);

    // 5. reset beats a simultaneous write
    cycle("x2_set", 1'b0, 1'b1, 5'd2, 32'h0000_0010);
    cycle("collide", 1'b1, 1'b1, 5'd2, 32'hAAAA_AAAA);
    check_value("x2_collide_const", mux_sel(reg_bus, 2), 32'h7FFF_EFFC);

    // 6. read during write: old before the edge, new after
    cycle("x9_11", 1'b0, 1'b1, 5'd9, 32'h11);
    reset = 1'b0; reg_write = 1'b1; write_register = 5'd9; write_data = 32'h22;
    #1;
    check_value("x9_pre_edge", mux_sel(reg_bus, 9), 32'h11);
    cycle("x9_22", 1'b0, 1'b1, 5'd9, 32'h22);
    check_value("x9_post_edge", mux_sel(reg_bus, 9), 32'h22);

    // Randomized traffic with occasional resets and idle cycles
    for (int i = 0; i < 400; i++) begin
      logic rst_v;
      logic we_v;
      rst_v = ($urandom_range(0, 39) == 0);
      we_v  = ($urandom_range(0, 3) != 0);
      cycle("rand", rst_v, we_v, 5'($urandom_range(0, 31)), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_register_bank
